// File: rtl/rv_regbank8.sv
// rv_regbank8: 8-entry register bank, x0 hardwired to zero, two registered read ports with write bypass, sticky multi-hot write error
module rv_regbank8 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       we_onehot,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic [2:0]       ra_addr,
  input  logic [2:0]       rb_addr,
  output logic             rd_valid,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             we_err,
  input  logic             err_clr
);
  logic [WIDTH-1:0] regs [8];
  logic             multi;
  logic [WIDTH-1:0] ra_next, rb_next;
  always_comb begin
    multi   = (we_onehot & (we_onehot - 8'd1)) != 8'd0;
    ra_next = ra_addr == 3'd0 ? '0 : (!multi && we_onehot[ra_addr]) ? wr_data : regs[ra_addr];
    rb_next = rb_addr == 3'd0 ? '0 : (!multi && we_onehot[rb_addr]) ? wr_data : regs[rb_addr];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      regs[i] <= rst ? '0 : (i != 0 && we_onehot[i] && !multi) ? wr_data : regs[i];
    rd_valid <= !rst && rd_req;
    ra_data  <= rst ? '0 : rd_req ? ra_next : ra_data;
    rb_data  <= rst ? '0 : rd_req ? rb_next : rb_data;
    we_err   <= rst ? 1'b0 : multi ? 1'b1 : err_clr ? 1'b0 : we_err;
  end
endmodule

// File: tb/tb_rv_regbank8.sv
// tb_rv_regbank8: directed and random checks of rv_regbank8 against an array-based reference model
module tb_rv_regbank8;
  logic        clk = 1'b0;
  logic        rst, rd_req, err_clr, rd_valid, we_err;
  logic [7:0]  we_onehot;
  logic [31:0] wr_data, ra_data, rb_data;
  logic [2:0]  ra_addr, rb_addr;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [8];
  logic        ev, ee;
  logic [31:0] ea, eb;
  rv_regbank8 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .we_onehot(we_onehot), .wr_data(wr_data),
    .rd_req(rd_req), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .rd_valid(rd_valid), .ra_data(ra_data), .rb_data(rb_data),
    .we_err(we_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic [7:0] we, input logic [31:0] wd,
                      input logic rq, input logic [2:0] a, input logic [2:0] b, input logic clr);
    int cnt;
    @(negedge clk);
    rst = r; we_onehot = we; wr_data = wd; rd_req = rq; ra_addr = a; rb_addr = b; err_clr = clr;
    cnt = $countones(we);
    if (r) begin
      foreach (mem[k]) mem[k] = '0;
      ev = 1'b0; ea = '0; eb = '0; ee = 1'b0;
    end else begin
      ev = rq;
      if (rq) begin
        ea = a == 0 ? 32'd0 : (cnt == 1 && we[a]) ? wd : mem[a];
        eb = b == 0 ? 32'd0 : (cnt == 1 && we[b]) ? wd : mem[b];
      end
      ee = cnt >= 2 ? 1'b1 : clr ? 1'b0 : ee;
      if (cnt == 1 && !we[0])
        for (int k = 1; k < 8; k++) if (we[k]) mem[k] = wd;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, ev});
    chk("ra_data", ra_data, ea);
    chk("rb_data", rb_data, eb);
    chk("we_err", {31'd0, we_err}, {31'd0, ee});
  endtask
  initial begin
    rst = 1'b1; we_onehot = '0; wr_data = '0; rd_req = 1'b0; ra_addr = '0; rb_addr = '0; err_clr = 1'b0;
    ev = 1'b0; ea = '0; eb = '0; ee = 1'b0;
    foreach (mem[k]) mem[k] = '0;
    step(1, 8'hFF, 32'hFFFF_FFFF, 1, 3'd3, 3'd5, 0);
    step(1, 8'hFF, 32'hFFFF_FFFF, 1, 3'd7, 3'd1, 0);
    chk("reset_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_ra", ra_data, 32'd0);
    for (int i = 0; i < 8; i += 2) step(0, 8'h00, 32'd0, 1, 3'(i), 3'(i + 1), 0);
    chk("post_reset_rb7", rb_data, 32'd0);
    step(0, 8'h08, 32'hDEAD_BEEF, 0, 3'd0, 3'd0, 0);
    step(0, 8'h00, 32'd0, 1, 3'd3, 3'd0, 0);
    chk("wr_rd_ra", ra_data, 32'hDEAD_BEEF);
    chk("wr_rd_rb", rb_data, 32'd0);
    step(0, 8'h20, 32'h1234_5678, 1, 3'd5, 3'd5, 0);
    chk("bypass_ra", ra_data, 32'h1234_5678);
    chk("bypass_rb", rb_data, 32'h1234_5678);
    step(0, 8'h01, 32'hFFFF_FFFF, 0, 3'd0, 3'd0, 0);
    step(0, 8'h00, 32'd0, 1, 3'd0, 3'd0, 0);
    chk("x0_ra", ra_data, 32'd0);
    chk("x0_err", {31'd0, we_err}, 32'd0);
    step(0, 8'h04, 32'h0000_00A5, 0, 3'd0, 3'd0, 0);
    step(0, 8'h06, 32'h0000_005A, 1, 3'd2, 3'd1, 0);
    chk("multi_old_r2", ra_data, 32'h0000_00A5);
    chk("multi_err", {31'd0, we_err}, 32'd1);
    step(0, 8'h00, 32'd0, 1, 3'd2, 3'd1, 1);
    chk("multi_r2_kept", ra_data, 32'h0000_00A5);
    chk("err_clr", {31'd0, we_err}, 32'd0);
    step(0, 8'h81, 32'h0BAD_0BAD, 0, 3'd0, 3'd0, 1);
    chk("set_wins", {31'd0, we_err}, 32'd1);
    step(0, 8'h02, 32'h1111_1111, 0, 3'd0, 3'd0, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 32'd0, 1, 3'(1 + (2 * i) % 7), 3'(1 + (2 * i + 1) % 7), 0);
    step(0, 8'h00, 32'd0, 0, 3'd1, 3'd2, 0);
    chk("hold_valid", {31'd0, rd_valid}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] we;
      int sel;
      sel = $urandom_range(0, 3);
      we = sel == 0 ? 8'h00 : sel == 3 ? 8'($urandom) : 8'h01 << $urandom_range(0, 7);
      step($urandom_range(0, 39) == 0, we, $urandom, $urandom_range(0, 3) != 0,
           3'($urandom), 3'($urandom), $urandom_range(0, 3) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv_regbank8.md
# rv_regbank8

Eight-entry general-purpose register bank for the RiscV datapath. It sits directly downstream of the 3-to-8 write-select decoder and consumes that decoder's eight one-hot outputs as its write-enable vector. It provides two registered read ports with same-cycle write-to-read bypass, hardwires entry 0 to zero (x0 semantics), and flags illegal multi-hot write vectors.

## Interface
Parameters:
- WIDTH, 32, data width of each register and of all data ports

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we_onehot  in  8  write-enable vector; bit k = decoder output Rk (bit 0 = R0 … bit 7 = R7)
- wr_data  in  WIDTH  write data, sampled when we_onehot is non-zero
- rd_req  in  1  read request; samples ra_addr/rb_addr this cycle
- ra_addr  in  3  read port A register index
- rb_addr  in  3  read port B register index
- rd_valid  out  1  high for one cycle when ra_data/rb_data carry the result of the previous cycle's rd_req
- ra_data  out  WIDTH  port A read result
- rb_data  out  WIDTH  port B read result
- we_err  out  1  sticky error: a multi-hot we_onehot was seen
- err_clr  in  1  clears we_err

## Operation
- Storage: regs[1..7], WIDTH bits each. Entry 0 is not stored and always reads as 0.
- Write classification per cycle, from we_onehot:
  - all zero: no write.
  - exactly one bit set, index k ≥ 1: regs[k] <= wr_data.
  - exactly one bit set, index 0: no write, no error (x0 writes discarded).
  - two or more bits set: no register written; we_err <= 1.
- Read: when rd_req = 1, each port independently captures:
  - 0 if its address is 0;
  - else wr_data if this cycle's write is a legal single-hot write to the same index (bypass);
  - else regs[addr].
  Both ports may address the same register; both return the same value.
- When rd_req = 0: rd_valid <= 0; ra_data/rb_data hold their last values.
- A multi-hot write never bypasses; reads in that cycle return the stored (old) contents.
- err_clr = 1 clears we_err at the next edge unless a multi-hot vector arrives in the same cycle, in which case we_err stays 1 (set wins).
- Reset (rst = 1 at an edge): regs[1..7] <= 0, rd_valid <= 0, ra_data <= 0, rb_data <= 0, we_err <= 0. Reset overrides any write, read, or err_clr in the same cycle. A read requested in the cycle reset is asserted is discarded.

## Timing
- Write latency: a write in cycle N is visible to a direct (non-bypass) read requested in cycle N+1.
- Read latency: 1 cycle. rd_req in cycle N → rd_valid = 1 and data valid in cycle N+1. Back-to-back rd_req yields rd_valid high every cycle.
- Bypass: a read and a write to the same index in cycle N → read data in cycle N+1 equals cycle-N wr_data.
- we_err asserts in the cycle after the offending vector; it has no combinational path from inputs.
- All outputs are registered. No input-to-output combinational paths.
- No backpressure. The consumer must accept rd_valid data in the cycle it appears.

## Test plan
- Reset: hold rst 2 cycles with we_onehot = 8'hFF and rd_req = 1 → all outputs 0; after release, reads of all 8 indices return 0.
- Write/read: write 32'hDEADBEEF with we_onehot = 8'h08 (reg 3), then rd_req with ra = 3, rb = 0 next cycle → one cycle later rd_valid = 1, ra_data = 32'hDEADBEEF, rb_data = 0.
- Bypass: in one cycle, we_onehot = 8'h20, wr_data = 32'h12345678, rd_req = 1, ra = rb = 5 → next cycle ra_data = rb_data = 32'h12345678.
- x0 discard: we_onehot = 8'h01, wr_data = 32'hFFFFFFFF, then read ra = 0 → ra_data = 0, we_err = 0.
- Multi-hot: reg 2 holds 32'hA5; apply we_onehot = 8'h06 with wr_data = 32'h5A → reg 2 still 32'hA5, reg 1 unchanged, we_err = 1 next cycle. err_clr alone → 0. err_clr together with another 8'h81 → stays 1.
- Back-to-back reads: rd_req high for 4 cycles reading regs 1–7 in rotation → rd_valid high for exactly 4 cycles, data matches the model each cycle; after rd_req drops, data holds.
